// File: rtl/par_to_seq_unloader.sv
// Parallel-to-serial frame unloader for the BCH datapath.
// Captures SHIFT_LEN words of BIT_WIDTH bits with one load strobe. It then replays them one word
// per accepted valid/ready transfer to the next serial stage.
// After the last transfer it spends one DONE cycle, then returns to IDLE.
// A load attempted while a frame is in flight is dropped and latches a sticky overflow flag.

module par_to_seq_unloader #(
  parameter int          DIRECTION = 1,
  parameter int unsigned SHIFT_LEN = 4,
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           in_ctr_Arst_n,
  input  logic                           in_ctr_Srst,
  input  logic                           in_ctr_en,
  input  logic                           in_ctr_ld,
  input  logic [BIT_WIDTH*SHIFT_LEN-1:0] in,
  input  logic                           in_ctr_rdy,
  output logic [BIT_WIDTH-1:0]           out,
  output logic                           out_valid,
  output logic                           out_last,
  output logic                           out_busy,
  output logic                           out_done,
  output logic                           out_err_ovf
);

  // One spare counter bit so SHIFT_LEN == 1 still yields a legal width.
  localparam int unsigned      CntW     = $clog2(SHIFT_LEN) + 1;
  localparam logic [CntW-1:0]  LastCnt  = CntW'(SHIFT_LEN - 1);
  localparam int unsigned      FirstIdx = (DIRECTION > 0) ? 0 : SHIFT_LEN - 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [BIT_WIDTH-1:0] word_q [SHIFT_LEN];
  logic [BIT_WIDTH-1:0] out_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;

  logic                 xfer;
  logic                 at_last;
  logic [BIT_WIDTH-1:0] next_word;
  int                   nxt_cnt;
  int                   nxt_sel;

  // Handshake decode and selection of the word that follows the one currently on out.
  always_comb begin
    xfer      = in_ctr_en & valid_q & in_ctr_rdy;
    at_last   = (cnt_q == LastCnt);
    nxt_cnt   = int'(cnt_q) + 1;
    nxt_sel   = (DIRECTION > 0) ? nxt_cnt : int'(SHIFT_LEN) - 1 - nxt_cnt;
    next_word = '0;
    for (int k = 0; k < int'(SHIFT_LEN); k++) begin
      if (k == nxt_sel) begin
        next_word = word_q[k];
      end
    end
  end

  // Frame FSM with registered data and status outputs; the enable freezes everything.
  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < int'(SHIFT_LEN); k++) begin
        word_q[k] <= '0;
      end
    end else if (in_ctr_Srst) begin
      // Synchronous clear mirrors reset and takes priority over a coincident load.
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < int'(SHIFT_LEN); k++) begin
        word_q[k] <= '0;
      end
    end else if (in_ctr_en) begin
      if (in_ctr_ld && (state_q != StIdle)) begin
        ovf_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (in_ctr_ld) begin
            for (int k = 0; k < int'(SHIFT_LEN); k++) begin
              word_q[k] <= in[k*BIT_WIDTH +: BIT_WIDTH];
            end
            // The first word goes straight from the input so it is valid one cycle after load.
            out_q   <= in[FirstIdx*BIT_WIDTH +: BIT_WIDTH];
            cnt_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (xfer) begin
            if (at_last) begin
              // out keeps the last word; only valid drops.
              cnt_q   <= '0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
              out_q <= next_word;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign out         = out_q;
  assign out_valid   = valid_q;
  assign out_last    = valid_q & at_last;
  assign out_busy    = busy_q;
  assign out_done    = done_q;
  assign out_err_ovf = ovf_q;

endmodule

// File: tb/tb_par_to_seq_unloader.sv
// Directed bench for par_to_seq_unloader. It drives three instances:
//   - a forward 4x8 instance and a backward 4x8 instance, which share their stimulus;
//   - a 1x5 instance for the single-word case.

module tb_par_to_seq_unloader;

  logic        clk = 1'b0;
  logic        arst_n, srst, en, ld, rdy;
  logic [31:0] din;
  logic        s_ld, s_rdy;
  logic [4:0]  s_din;

  logic [7:0]  f_out, b_out;
  logic        f_valid, f_last, f_busy, f_done, f_ovf;
  logic        b_valid, b_last, b_busy, b_done, b_ovf;
  logic [4:0]  s_out;
  logic        s_valid, s_last, s_busy, s_done, s_ovf;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  par_to_seq_unloader #(.DIRECTION(1), .SHIFT_LEN(4), .BIT_WIDTH(8)) u_fwd (
    .clk(clk), .in_ctr_Arst_n(arst_n), .in_ctr_Srst(srst), .in_ctr_en(en), .in_ctr_ld(ld),
    .in(din), .in_ctr_rdy(rdy), .out(f_out), .out_valid(f_valid), .out_last(f_last),
    .out_busy(f_busy), .out_done(f_done), .out_err_ovf(f_ovf)
  );

  par_to_seq_unloader #(.DIRECTION(0), .SHIFT_LEN(4), .BIT_WIDTH(8)) u_bwd (
    .clk(clk), .in_ctr_Arst_n(arst_n), .in_ctr_Srst(srst), .in_ctr_en(en), .in_ctr_ld(ld),
    .in(din), .in_ctr_rdy(rdy), .out(b_out), .out_valid(b_valid), .out_last(b_last),
    .out_busy(b_busy), .out_done(b_done), .out_err_ovf(b_ovf)
  );

  par_to_seq_unloader #(.DIRECTION(1), .SHIFT_LEN(1), .BIT_WIDTH(5)) u_one (
    .clk(clk), .in_ctr_Arst_n(arst_n), .in_ctr_Srst(srst), .in_ctr_en(en), .in_ctr_ld(s_ld),
    .in(s_din), .in_ctr_rdy(s_rdy), .out(s_out), .out_valid(s_valid), .out_last(s_last),
    .out_busy(s_busy), .out_done(s_done), .out_err_ovf(s_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fb(input string tag, input logic [7:0] eo_f, input logic [7:0] eo_b,
                        input logic ev, input logic el, input logic eb, input logic ed);
    chk({tag, ".f_out"},   32'(f_out),   32'(eo_f));
    chk({tag, ".b_out"},   32'(b_out),   32'(eo_b));
    chk({tag, ".f_valid"}, 32'(f_valid), 32'(ev));
    chk({tag, ".b_valid"}, 32'(b_valid), 32'(ev));
    chk({tag, ".f_last"},  32'(f_last),  32'(el));
    chk({tag, ".b_last"},  32'(b_last),  32'(el));
    chk({tag, ".f_busy"},  32'(f_busy),  32'(eb));
    chk({tag, ".b_busy"},  32'(b_busy),  32'(eb));
    chk({tag, ".f_done"},  32'(f_done),  32'(ed));
    chk({tag, ".b_done"},  32'(b_done),  32'(ed));
  endtask

  task automatic chk_ovf(input string tag, input logic e);
    chk({tag, ".f_ovf"}, 32'(f_ovf), 32'(e));
    chk({tag, ".b_ovf"}, 32'(b_ovf), 32'(e));
  endtask

  task automatic chk_s(input string tag, input logic [4:0] eo, input logic ev, input logic el,
                       input logic eb, input logic ed);
    chk({tag, ".s_out"},   32'(s_out),   32'(eo));
    chk({tag, ".s_valid"}, 32'(s_valid), 32'(ev));
    chk({tag, ".s_last"},  32'(s_last),  32'(el));
    chk({tag, ".s_busy"},  32'(s_busy),  32'(eb));
    chk({tag, ".s_done"},  32'(s_done),  32'(ed));
  endtask

  // Back-pressure table: rdy driven during cycle i and expected outputs in that cycle.
  logic       bp_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] bp_f   [7] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h44};
  logic [7:0] bp_b   [7] = '{8'h44, 8'h33, 8'h33, 8'h33, 8'h22, 8'h11, 8'h11};
  logic       bp_l   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0; srst = 1'b0; en = 1'b1; ld = 1'b0; rdy = 1'b1; din = '0;
    s_ld = 1'b0; s_rdy = 1'b1; s_din = '0;

    // Reset state
    #1;
    chk_fb("rst", 8'h00, 8'h00, 0, 0, 0, 0);
    chk_ovf("rst", 0);
    chk_s("rst", 5'h00, 0, 0, 0, 0);
    chk("rst.s_ovf", 32'(s_ovf), 32'd0);
    step(); step();
    arst_n = 1'b1;
    step();
    chk_fb("idle", 8'h00, 8'h00, 0, 0, 0, 0);

    // Plain frame: forward 11,22,33,44 and backward 44,33,22,11
    ld = 1'b1; din = 32'h4433_2211;
    step();
    ld = 1'b0; din = '0;
    chk_fb("fr.w0", 8'h11, 8'h44, 1, 0, 1, 0);
    step(); chk_fb("fr.w1", 8'h22, 8'h33, 1, 0, 1, 0);
    step(); chk_fb("fr.w2", 8'h33, 8'h22, 1, 0, 1, 0);
    step(); chk_fb("fr.w3", 8'h44, 8'h11, 1, 1, 1, 0);
    step(); chk_fb("fr.done", 8'h44, 8'h11, 0, 0, 1, 1);
    step(); chk_fb("fr.idle", 8'h44, 8'h11, 0, 0, 0, 0);
    chk_ovf("fr", 0);

    // Back-pressure
    ld = 1'b1; din = 32'h4433_2211;
    step();
    ld = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk_fb($sformatf("bp.c%0d", i), bp_f[i], bp_b[i], 1, bp_l[i], 1, 0);
      rdy = bp_rdy[i];
      step();
    end
    chk_fb("bp.done", 8'h44, 8'h11, 0, 0, 1, 1);
    rdy = 1'b1;
    step(); chk_fb("bp.idle", 8'h44, 8'h11, 0, 0, 0, 0);

    // Load during SHIFT is ignored and flags overflow; enable low freezes the frame
    ld = 1'b1; din = 32'h4433_2211;
    step();
    ld = 1'b0;
    chk_fb("ov.w0", 8'h11, 8'h44, 1, 0, 1, 0);
    ld = 1'b1; din = 32'hAABB_CCDD;
    step();
    ld = 1'b0;
    chk_fb("ov.w1", 8'h22, 8'h33, 1, 0, 1, 0);
    chk_ovf("ov.set", 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_fb($sformatf("ov.frz%0d", i), 8'h22, 8'h33, 1, 0, 1, 0);
    end
    en = 1'b1;
    step(); chk_fb("ov.w2", 8'h33, 8'h22, 1, 0, 1, 0);
    step(); chk_fb("ov.w3", 8'h44, 8'h11, 1, 1, 1, 0);
    step(); chk_fb("ov.done", 8'h44, 8'h11, 0, 0, 1, 1);
    step(); chk_fb("ov.idle", 8'h44, 8'h11, 0, 0, 0, 0);
    chk_ovf("ov.sticky", 1);

    // Srst together with ld: clear wins, load dropped
    srst = 1'b1; ld = 1'b1; din = 32'h4433_2211;
    step();
    srst = 1'b0; ld = 1'b0;
    chk_fb("sr", 8'h00, 8'h00, 0, 0, 0, 0);
    chk_ovf("sr", 0);
    step(); chk_fb("sr.idle", 8'h00, 8'h00, 0, 0, 0, 0);

    // Async reset after the second word aborts the frame without done
    ld = 1'b1; din = 32'h4433_2211;
    step();
    ld = 1'b0;
    chk_fb("ar.w0", 8'h11, 8'h44, 1, 0, 1, 0);
    step(); chk_fb("ar.w1", 8'h22, 8'h33, 1, 0, 1, 0);
    #2 arst_n = 1'b0;
    #1 chk_fb("ar.now", 8'h00, 8'h00, 0, 0, 0, 0);
    step(); chk_fb("ar.hold", 8'h00, 8'h00, 0, 0, 0, 0);
    arst_n = 1'b1;
    step(); chk_fb("ar.idle", 8'h00, 8'h00, 0, 0, 0, 0);
    ld = 1'b1;
    step();
    ld = 1'b0;
    chk_fb("ar.re0", 8'h11, 8'h44, 1, 0, 1, 0);
    step(); chk_fb("ar.re1", 8'h22, 8'h33, 1, 0, 1, 0);
    step(); chk_fb("ar.re2", 8'h33, 8'h22, 1, 0, 1, 0);
    step(); chk_fb("ar.re3", 8'h44, 8'h11, 1, 1, 1, 0);
    step(); chk_fb("ar.done", 8'h44, 8'h11, 0, 0, 1, 1);
    step();

    // Single-word frames, back-to-back with a period of 3 cycles
    s_ld = 1'b1; s_din = 5'h15;
    step();
    s_ld = 1'b0;
    chk_s("one.w0", 5'h15, 1, 1, 1, 0);
    step(); chk_s("one.done", 5'h15, 0, 0, 1, 1);
    step(); chk_s("one.idle", 5'h15, 0, 0, 0, 0);
    s_ld = 1'b1; s_din = 5'h0A;
    step();
    s_ld = 1'b0;
    chk_s("one.b2b", 5'h0A, 1, 1, 1, 0);
    step(); chk_s("one.done2", 5'h0A, 0, 0, 1, 1);
    step(); chk_s("one.idle2", 5'h0A, 0, 0, 0, 0);
    chk("one.s_ovf", 32'(s_ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/par_to_seq_unloader.md
Name: par_to_seq_unloader

Overview:
- Downstream companion of the sequential-to-simultaneous collector register in the BCH datapath.
- Captures SHIFT_LEN words of BIT_WIDTH bits in parallel with one load strobe.
- Replays them one word per accepted transfer, using a valid/ready handshake, to the next serial stage (e.g. Chien/correction feed).
- Provides busy, last-word and done indications, plus a sticky load-overflow flag.

Parameters:
- DIRECTION, 1: >0 emits word 0 first (LSB slice first); <=0 emits word SHIFT_LEN-1 first.
- SHIFT_LEN, 4: number of words per parallel frame; must be >=1.
- BIT_WIDTH, 8: width of one word.

Ports:
- clk  input  1  rising-edge clock.
- in_ctr_Arst_n  input  1  asynchronous active-low reset.
- in_ctr_Srst  input  1  synchronous clear, active-high; same effect as reset on the next edge.
- in_ctr_en  input  1  global enable; when 0 all state holds, including counter, FSM, data and flags.
- in_ctr_ld  input  1  parallel load strobe.
- in  input  BIT_WIDTH*SHIFT_LEN  parallel frame; word k = in[BIT_WIDTH*(k+1)-1 : BIT_WIDTH*k].
- in_ctr_rdy  input  1  downstream ready.
- out  output  BIT_WIDTH  current serial word (registered).
- out_valid  output  1  out holds a valid word.
- out_last  output  1  current valid word is the final word of the frame.
- out_busy  output  1  frame in progress; high in SHIFT and DONE.
- out_done  output  1  one-cycle pulse after the last transfer.
- out_err_ovf  output  1  sticky; set by a load attempted while busy.

Behaviour:
- Reset (async low, or Srst at edge):
  - FSM goes to IDLE; counter = 0; word store = 0.
  - out = 0; out_valid = 0; out_last = 0; out_busy = 0; out_done = 0; out_err_ovf = 0.
  - Async reset asserted mid-frame aborts the frame immediately, with no done pulse.
- Transfer definition: xfer = in_ctr_en & out_valid & in_ctr_rdy.
- IDLE:
  - On in_ctr_en & in_ctr_ld, capture all words and move to SHIFT at the next edge.
  - In that next cycle, out = first word, out_valid = 1, out_busy = 1.
  - Latency from load edge to first valid word: 1 cycle.
- SHIFT:
  - Counter cnt, width ceil(log2(SHIFT_LEN))+1, counts completed transfers.
  - out = word[cnt] when DIRECTION>0, else word[SHIFT_LEN-1-cnt].
  - On xfer with cnt < SHIFT_LEN-1: increment cnt; out advances to the next word on the next edge.
  - No xfer (rdy low or en low): out, out_valid and cnt hold. Data must never be skipped or duplicated.
  - out_last = out_valid & (cnt == SHIFT_LEN-1).
  - On xfer while out_last: go to DONE, out_valid = 0, cnt = 0.
- DONE (one cycle, only if in_ctr_en): out_done = 1, out_busy = 1, then go to IDLE. With in_ctr_en low, DONE holds.
- Load while busy:
  - in_ctr_en & in_ctr_ld in SHIFT or DONE is ignored; the frame is not disturbed.
  - out_err_ovf sets the next edge and is cleared only by reset or Srst.
- A load in the IDLE cycle immediately after DONE is accepted, so the minimum frame period is SHIFT_LEN+2 cycles.
- SHIFT_LEN == 1: out_last equals out_valid; the frame is 1 transfer, then DONE.
- Simultaneous Srst and ld: Srst wins and the load is dropped.
- Simultaneous async reset and anything: reset wins.
- out is held at its last value when out_valid = 0, and is 0 after reset.

Test Plan:
- Forward frame (DIRECTION=1, SHIFT_LEN=4, BIT_WIDTH=8), rdy=1, load in=0x44332211:
  - out = 11,22,33,44 on 4 consecutive cycles starting 1 cycle after load.
  - out_last high only with 44.
  - out_done pulse on the following cycle; busy high for 5 cycles.
- Backward frame (DIRECTION=0), same load:
  - out = 44,33,22,11; out_last with 11.
- Back-pressure: rdy pattern 1,0,0,1,1,0,1 with the same frame:
  - each word held while rdy=0; sequence 11,22,33,44 delivered exactly once; done after the 4th transfer.
- Overflow and enable:
  - Load 0xAABBCCDD during SHIFT: ignored; original frame completes; out_err_ovf = 1 and stays 1 until Srst.
  - in_ctr_en=0 for 3 mid-frame cycles freezes all outputs.
- Reset mid-frame:
  - Drop in_ctr_Arst_n asynchronously after the 2nd word: all outputs go to 0 immediately, no out_done.
  - A new load after release restarts from word 0.
- SHIFT_LEN=1, BIT_WIDTH=5, load 0x15:
  - out = 0x15 with valid=last=1 for one cycle; done on the next cycle.
  - Back-to-back load in the IDLE cycle is accepted, giving a period of 3 cycles.
